// File: rtl/fakeram_ctrl_pkg.sv
// Shared types for the fakeram port controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fakeram_ctrl_pkg;

   // Controller phase: zero-scrub of the array after reset, then normal service.
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Replicated to build the all-ones write mask at any data width.
   localparam logic MASK_BIT_ON = 1'b1;

endpackage

// File: rtl/fakeram_rsp_fifo.sv
// Read-response buffer: circular buffer with occupancy count and head output.
// Latency: a push is visible at head_o the cycle after it is written.
// Backpressure: none internally; the owner must never push into a full buffer.
// Ports: clk/rst, push_i + push_dat_i write, pop_i retires head (ignored when
// empty), head_o current head, count_o occupancy.
module fakeram_rsp_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (push_i && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!push_i && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_d;
      end
   end

   // The credit check upstream makes overflow unreachable.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(push_i && !do_pop && (count_q == CNT_W'(DEPTH))));
      end
   end

endmodule

// File: rtl/fakeram_port_ctrl.sv
// Initiator-side controller for a 1-cycle-latency single-port fakeram macro.
// Latency: read accept to rsp_valid is 2 cycles; writes produce no response.
// Backpressure: reads are accepted only while FIFO occupancy plus the in-flight
// read leaves room; writes are always accepted once the zero-scrub is done.
// Ports: req_* request channel (read / masked write), rsp_* read-data channel,
// init_done scrub status, mem_* macro pins (mem_rd returns data next cycle).
module fakeram_port_ctrl
   import fakeram_ctrl_pkg::*;
#(
   parameter int BITS       = 34,
   parameter int WORD_DEPTH = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int RSP_DEPTH  = 4,
   parameter int INIT_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [BITS-1:0]       req_wdata,
   input  logic [BITS-1:0]       req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [BITS-1:0]       rsp_data,
   output logic                  init_done,
   output logic                  mem_ce,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [BITS-1:0]       mem_wd,
   output logic [BITS-1:0]       mem_w_mask,
   input  logic [BITS-1:0]       mem_rd
);

   localparam int     CNT_W     = $clog2(RSP_DEPTH + 1);
   localparam int     SCRUB_W   = ADDR_WIDTH + 1;
   localparam state_e RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

   state_e             state_q, state_d;
   logic [SCRUB_W-1:0] scrub_cnt_q, scrub_cnt_d;
   logic               init_done_q, init_done_d;
   logic               inflight_q, inflight_d;
   logic [CNT_W-1:0]   fifo_count;
   logic               credit_ok;
   logic               accept;

   // Credit counts only what is already committed; a pop this cycle is not
   // credited until it has actually retired an entry.
   assign credit_ok = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight_q))
                      < (CNT_W + 1)'(RSP_DEPTH);

   always_comb begin
      state_d     = state_q;
      scrub_cnt_d = scrub_cnt_q;
      init_done_d = init_done_q;
      inflight_d  = 1'b0;
      req_ready   = 1'b0;
      accept      = 1'b0;
      mem_ce      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wd      = '0;
      mem_w_mask  = '0;
      case (state_q)
         ST_INIT: begin
            mem_ce      = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = scrub_cnt_q[ADDR_WIDTH-1:0];
            mem_w_mask  = {BITS{MASK_BIT_ON}};
            scrub_cnt_d = scrub_cnt_q + 1'b1;
            // The extra counter bit flags the word after the last one.
            if (scrub_cnt_d == SCRUB_W'(WORD_DEPTH)) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         default: begin
            req_ready = req_we || credit_ok;
            accept    = req_valid && req_ready;
            if (accept) begin
               mem_ce     = 1'b1;
               mem_we     = req_we;
               mem_addr   = req_addr;
               mem_wd     = req_wdata;
               mem_w_mask = req_wmask;
               inflight_d = !req_we;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RST_STATE;
         scrub_cnt_q <= '0;
         init_done_q <= (INIT_EN == 0);
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         scrub_cnt_q <= scrub_cnt_d;
         init_done_q <= init_done_d;
         inflight_q  <= inflight_d;
      end
   end

   assign init_done = init_done_q;
   assign rsp_valid = (fifo_count != '0);

   // mem_rd is valid exactly while a read is in flight.
   fakeram_rsp_fifo #(
      .WIDTH (BITS),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (inflight_q),
      .push_dat_i (mem_rd),
      .pop_i      (rsp_ready),
      .head_o     (rsp_data),
      .count_o    (fifo_count)
   );

endmodule
